// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes, EXE FSM states and datapath select constants.
package pipe_pkg;

  localparam logic [3:0] AluNop = 4'd0;
  localparam logic [3:0] AluAdd = 4'd1;
  localparam logic [3:0] AluSub = 4'd2;
  localparam logic [3:0] AluAnd = 4'd3;
  localparam logic [3:0] AluOr  = 4'd4;
  localparam logic [3:0] AluXor = 4'd5;
  localparam logic [3:0] AluSll = 4'd6;
  localparam logic [3:0] AluSrl = 4'd7;
  localparam logic [3:0] AluSra = 4'd8;
  localparam logic [3:0] AluSlt = 4'd9;
  localparam logic [3:0] AluBeq = 4'd10;
  localparam logic [3:0] AluBne = 4'd11;
  localparam logic [3:0] AluMul = 4'd12;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StMulBusy = 2'd1;
  localparam logic [1:0] StMulDone = 2'd2;

  localparam logic LwAluSrc     = 1'b0;
  localparam logic LwMemSrc     = 1'b1;
  localparam logic MvAluSrc     = 1'b0;
  localparam logic MvRegSrc     = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic WriteDisable = 1'b0;

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE operand bundle in, EXE/MEM register and hazard/branch signals out.
interface exe_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CTRL_W = 4
);
  logic [ADDR_W-1:0] exe_pc_o;
  logic [ADDR_W-1:0] exe_branch_addr;
  logic [DATA_W-1:0] exe_reg1_o;
  logic [DATA_W-1:0] exe_reg2_o;
  logic [DATA_W-1:0] exe_sw_o;
  logic [DATA_W-1:0] exe_write_o;
  logic [CTRL_W-1:0] exe_aluctrl;
  logic              exe_lwsrc;
  logic              exe_movsrc;
  logic              exe_DM_read;
  logic              exe_DM_write;
  logic              flush;
  logic              stall_req;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_pc_o;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_sw_o;
  logic [DATA_W-1:0] mem_write_o;
  logic              mem_lwsrc;
  logic              mem_DM_read;
  logic              mem_DM_write;

  modport master (
    output exe_pc_o, exe_branch_addr, exe_reg1_o, exe_reg2_o, exe_sw_o, exe_write_o,
           exe_aluctrl, exe_lwsrc, exe_movsrc, exe_DM_read, exe_DM_write, flush,
    input  stall_req, branch_taken, branch_target, mem_valid, mem_pc_o, mem_alu_result,
           mem_sw_o, mem_write_o, mem_lwsrc, mem_DM_read, mem_DM_write
  );

  modport slave (
    input  exe_pc_o, exe_branch_addr, exe_reg1_o, exe_reg2_o, exe_sw_o, exe_write_o,
           exe_aluctrl, exe_lwsrc, exe_movsrc, exe_DM_read, exe_DM_write, flush,
    output stall_req, branch_taken, branch_target, mem_valid, mem_pc_o, mem_alu_result,
           mem_sw_o, mem_write_o, mem_lwsrc, mem_DM_read, mem_DM_write
  );
endinterface

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
module exe_mul_iter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_mcand,
  input  logic [DATA_W-1:0] i_mplier,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);
  localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CntW-1:0]   r_cnt;
  logic              r_busy;

  // High during the cycle that performs the final iteration.
  assign o_done    = r_busy && (r_cnt == CntW'(MUL_CYCLES - 1));
  assign o_busy    = r_busy;
  assign o_product = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CntW'(1);
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, branch resolve, multi-cycle multiply and EXE/MEM register.
module exe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MUL_CYCLES = 32
) (
  input logic       clk,
  input logic       rst,
  exe_stage_if.slave bus
);
  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [CTRL_W-1:0] w_ctrl;
  logic              w_is_mul;
  logic              w_is_branch;
  logic              w_idle;
  logic              w_busy_st;
  logic              w_mul_start;
  logic              w_mul_abort;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_product;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_result;
  logic              w_branch_cond;
  logic              w_stall;
  logic              w_bubble;

  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_pc;
  logic [DATA_W-1:0] r_mem_result;
  logic [DATA_W-1:0] r_mem_sw;
  logic [DATA_W-1:0] r_mem_write;
  logic              r_mem_lwsrc;
  logic              r_mem_rd;
  logic              r_mem_wr;

  assign w_ctrl      = bus.exe_aluctrl;
  assign w_is_mul    = (w_ctrl == CTRL_W'(AluMul));
  assign w_is_branch = (w_ctrl == CTRL_W'(AluBeq)) || (w_ctrl == CTRL_W'(AluBne));
  assign w_idle      = (r_state == StIdle);
  assign w_busy_st   = (r_state == StMulBusy);
  assign w_mul_start = !rst && w_idle && w_is_mul && !bus.flush;
  assign w_mul_abort = w_busy_st && bus.flush;

  // Reset and flush both drop the stall combinationally so the hazard unit never sees a stale hold.
  assign w_stall  = !rst && !bus.flush && ((w_idle && w_is_mul) || (w_busy_st && w_mul_busy));
  assign w_bubble = w_stall || bus.flush;

  exe_mul_iter #(
    .DATA_W    (DATA_W),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mul_start),
    .i_abort  (w_mul_abort),
    .i_mcand  (bus.exe_reg1_o),
    .i_mplier (bus.exe_reg2_o),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_product(w_product)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_mul_start) w_state_next = StMulBusy;
      StMulBusy: begin
        if (bus.flush)      w_state_next = StIdle;
        else if (w_mul_done) w_state_next = StMulDone;
      end
      StMulDone: w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_alu         = '0;
    w_branch_cond = 1'b0;
    case (w_ctrl)
      CTRL_W'(AluAdd): w_alu = bus.exe_reg1_o + bus.exe_reg2_o;
      CTRL_W'(AluSub): w_alu = bus.exe_reg1_o - bus.exe_reg2_o;
      CTRL_W'(AluAnd): w_alu = bus.exe_reg1_o & bus.exe_reg2_o;
      CTRL_W'(AluOr):  w_alu = bus.exe_reg1_o | bus.exe_reg2_o;
      CTRL_W'(AluXor): w_alu = bus.exe_reg1_o ^ bus.exe_reg2_o;
      CTRL_W'(AluSll): w_alu = bus.exe_reg1_o << bus.exe_reg2_o[4:0];
      CTRL_W'(AluSrl): w_alu = bus.exe_reg1_o >> bus.exe_reg2_o[4:0];
      CTRL_W'(AluSra): w_alu = $unsigned($signed(bus.exe_reg1_o) >>> bus.exe_reg2_o[4:0]);
      CTRL_W'(AluSlt): w_alu = {{(DATA_W-1){1'b0}},
                                ($signed(bus.exe_reg1_o) < $signed(bus.exe_reg2_o))};
      CTRL_W'(AluBeq): w_branch_cond = (bus.exe_reg1_o == bus.exe_reg2_o);
      CTRL_W'(AluBne): w_branch_cond = (bus.exe_reg1_o != bus.exe_reg2_o);
      default:         w_alu = '0;
    endcase
  end

  always_comb begin
    if (r_state == StMulDone)          w_result = w_product;
    else if (bus.exe_movsrc == MvRegSrc) w_result = bus.exe_reg2_o;
    else                               w_result = w_alu;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_valid  <= 1'b0;
      r_mem_pc     <= '0;
      r_mem_result <= '0;
      r_mem_sw     <= '0;
      r_mem_write  <= '0;
      r_mem_lwsrc  <= LwAluSrc;
      r_mem_rd     <= ReadDisable;
      r_mem_wr     <= WriteDisable;
    end else begin
      r_mem_pc    <= bus.exe_pc_o;
      r_mem_sw    <= bus.exe_sw_o;
      r_mem_write <= bus.exe_write_o;
      r_mem_lwsrc <= bus.exe_lwsrc;
      if (w_bubble) begin
        r_mem_valid  <= 1'b0;
        r_mem_result <= '0;
        r_mem_rd     <= ReadDisable;
        r_mem_wr     <= WriteDisable;
      end else begin
        r_mem_valid  <= 1'b1;
        r_mem_result <= w_result;
        r_mem_rd     <= w_is_branch ? ReadDisable : bus.exe_DM_read;
        r_mem_wr     <= w_is_branch ? WriteDisable : bus.exe_DM_write;
      end
    end
  end

  assign bus.stall_req      = w_stall;
  assign bus.branch_taken   = !rst && w_idle && !bus.flush && w_branch_cond;
  assign bus.branch_target  = bus.exe_branch_addr;
  assign bus.mem_valid      = r_mem_valid;
  assign bus.mem_pc_o       = r_mem_pc;
  assign bus.mem_alu_result = r_mem_result;
  assign bus.mem_sw_o       = r_mem_sw;
  assign bus.mem_write_o    = r_mem_write;
  assign bus.mem_lwsrc      = r_mem_lwsrc;
  assign bus.mem_DM_read    = r_mem_rd;
  assign bus.mem_DM_write   = r_mem_wr;
endmodule

// File: tb/tb_exe_stage.sv
// Directed plus randomized checks of exe_stage against an arithmetic reference model.
module tb_exe_stage;
  localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_SLL = 4'd6,  OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8,  OP_SLT = 4'd9,  OP_BEQ = 4'd10, OP_BNE = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] d_pc, d_baddr, d_sw, d_wr;
  logic        d_lw, d_rd, d_we;

  exe_stage_if #(.DATA_W(32), .ADDR_W(32), .CTRL_W(4)) bus ();

  exe_stage #(.DATA_W(32), .ADDR_W(32), .CTRL_W(4), .MUL_CYCLES(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    logic [31:0] ones;
    sh   = b % 32;
    ones = 32'hFFFF_FFFF;
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_SLL: return a << sh;
      OP_SRL: return a >> sh;
      OP_SRA: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      OP_SLT: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_common();
    d_pc    = $urandom; d_baddr = $urandom; d_sw = $urandom; d_wr = $urandom;
    d_lw    = 1'($urandom); d_rd = 1'($urandom); d_we = 1'($urandom);
    bus.exe_pc_o = d_pc; bus.exe_branch_addr = d_baddr; bus.exe_sw_o = d_sw;
    bus.exe_write_o = d_wr; bus.exe_lwsrc = d_lw; bus.exe_DM_read = d_rd;
    bus.exe_DM_write = d_we;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mov, input logic fl);
    bus.exe_aluctrl = op; bus.exe_reg1_o = a; bus.exe_reg2_o = b;
    bus.exe_movsrc = mov; bus.flush = fl;
  endtask

  task automatic chk_mem_zero(input string tag);
    chk({tag, "_valid"}, bus.mem_valid, 0);
    chk({tag, "_pc"}, bus.mem_pc_o, 0);
    chk({tag, "_result"}, bus.mem_alu_result, 0);
    chk({tag, "_sw"}, bus.mem_sw_o, 0);
    chk({tag, "_write"}, bus.mem_write_o, 0);
    chk({tag, "_lwsrc"}, bus.mem_lwsrc, 0);
    chk({tag, "_rd"}, bus.mem_DM_read, 0);
    chk({tag, "_wr"}, bus.mem_DM_write, 0);
  endtask

  // Entered and left at a falling edge; one instruction, one cycle.
  task automatic alu_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mov, input logic fl);
    logic        is_br, exp_taken;
    logic [31:0] exp_res;
    set_common();
    set_op(op, a, b, mov, fl);
    is_br     = (op == OP_BEQ) || (op == OP_BNE);
    exp_taken = !fl && (((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b)));
    exp_res   = mov ? b : model(op, a, b);
    #1;
    chk("alu_stall", bus.stall_req, 0);
    chk("branch_taken", bus.branch_taken, exp_taken);
    chk("branch_target", bus.branch_target, d_baddr);
    @(posedge clk); @(negedge clk);
    if (fl) begin
      chk("flush_valid", bus.mem_valid, 0);
      chk("flush_result", bus.mem_alu_result, 0);
      chk("flush_rd", bus.mem_DM_read, 0);
      chk("flush_wr", bus.mem_DM_write, 0);
    end else begin
      chk("alu_valid", bus.mem_valid, 1);
      chk("alu_result", bus.mem_alu_result, exp_res);
      chk("alu_rd", bus.mem_DM_read, is_br ? 1'b0 : d_rd);
      chk("alu_wr", bus.mem_DM_write, is_br ? 1'b0 : d_we);
      chk("alu_pc", bus.mem_pc_o, d_pc);
      chk("alu_sw", bus.mem_sw_o, d_sw);
      chk("alu_write", bus.mem_write_o, d_wr);
      chk("alu_lwsrc", bus.mem_lwsrc, d_lw);
    end
  endtask

  // Holds the MUL inputs stable for the whole residency, as the upstream contract requires.
  task automatic mul_run(input logic [31:0] a, input logic [31:0] b);
    int          stalls;
    logic [31:0] prod;
    prod = a * b;
    set_common();
    set_op(OP_MUL, a, b, 1'b0, 1'b0);
    stalls = 0;
    #1;
    while (bus.stall_req === 1'b1 && stalls < 100) begin
      stalls++;
      chk("mul_no_branch", bus.branch_taken, 0);
      @(posedge clk); @(negedge clk);
      chk("mul_bubble", bus.mem_valid, 0);
    end
    chk("mul_stall_cycles", stalls, 33);
    @(posedge clk); @(negedge clk);
    chk("mul_valid", bus.mem_valid, 1);
    chk("mul_result", bus.mem_alu_result, prod);
    chk("mul_pc", bus.mem_pc_o, d_pc);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;

    set_common();
    set_op(OP_NOP, 0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_common();
      set_op(4'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      #1;
      chk("rst_stall", bus.stall_req, 0);
      chk("rst_taken", bus.branch_taken, 0);
      @(posedge clk); @(negedge clk);
      chk_mem_zero("rst");
    end
    rst = 1'b0;

    alu_step(OP_ADD, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    alu_step(OP_SRA, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
    alu_step(OP_BEQ, 32'd7, 32'd7, 1'b0, 1'b0);
    alu_step(OP_BNE, 32'd7, 32'd7, 1'b0, 1'b0);
    alu_step(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    alu_step(OP_XOR, 32'h1234_5678, 32'hAAAA_AAAA, 1'b1, 1'b0);
    alu_step(OP_BEQ, 32'd9, 32'd9, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == OP_MUL) op = OP_SUB;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      alu_step(op, a, b, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    mul_run(32'h0001_2345, 32'h0000_0010);
    mul_run($urandom, $urandom);
    mul_run($urandom, $urandom);
    alu_step(OP_ADD, 32'd40, 32'd2, 1'b0, 1'b0);

    // Flush partway through a multiply.
    set_common();
    set_op(OP_MUL, 32'd123, 32'd456, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk); @(negedge clk);
    end
    #1;
    chk("pre_flush_stall", bus.stall_req, 1);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall_drop", bus.stall_req, 0);
    @(posedge clk); @(negedge clk);
    chk("flush_bubble_valid", bus.mem_valid, 0);
    chk("flush_bubble_result", bus.mem_alu_result, 0);
    alu_step(OP_ADD, 32'd5, 32'd6, 1'b0, 1'b0);

    // Reset partway through a multiply.
    set_common();
    set_op(OP_MUL, 32'd77, 32'd88, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    set_op(OP_NOP, 0, 0, 1'b0, 1'b0);
    #1;
    chk("mid_rst_stall", bus.stall_req, 0);
    chk_mem_zero("mid_rst");
    alu_step(OP_SUB, 32'd3, 32'd5, 1'b0, 1'b0);
    mul_run($urandom, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
